// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scheduler and related sprite logic.
// Contents: RAM address defaults, attribute word field positions, FSM state encoding.
package sprite_pkg;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COORD_W = 10;

  localparam logic [ADDR_W-1:0] ATTR_BASE_DEF = 9'h100;
  localparam logic [ADDR_W-1:0] PAT_BASE_DEF  = 9'h000;

  // word0 = {en, 5'b0, y[9:0]}, word1 = {6'b0, x[9:0]}
  localparam int unsigned EN_BIT = 15;
  localparam int unsigned Y_MSB  = 9;
  localparam int unsigned X_MSB  = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_Y   = 3'd1,
    S_CHK    = 3'd2,
    S_RD_X   = 3'd3,
    S_RD_PAT = 3'd4,
    S_LOAD   = 3'd5,
    S_NEXT   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/sprite_y_match.sv
// Vertical visibility test for one sprite against a scanline.
// Ports: i_en sprite enable, i_y sprite top line, i_line scanline;
//        o_hit_c sprite covers the line, o_row_c pattern row within the sprite.
// The distance wraps modulo 1024 so sprites straddling the bottom edge show at the top.
module sprite_y_match
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_H = 16,
  parameter int unsigned ROW_W = $clog2(SPR_H)
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_line,
  output logic               o_hit_c,
  output logic [ROW_W-1:0]   o_row_c
);

  logic [COORD_W-1:0] w_d;

  assign w_d     = i_line - i_y;
  // d < SPR_H with SPR_H a power of two: all bits above the row field are zero
  assign o_hit_c = i_en && (w_d[COORD_W-1:ROW_W] == '0);
  assign o_row_c = w_d[ROW_W-1:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite fetch sequencer on the sprite RAM read port (px_clk domain).
// On i_line_start it scans the attribute table, and for each sprite visible on
// i_next_line fetches the pattern row and loads it into the next free slot.
// Ports: px_clk, rst (sync, active-high); i_line_start/i_next_line start a scan;
//        o_ram_addr/i_ram_rdata RAM read port (1-cycle latency); o_busy port ownership;
//        o_slot_clr/o_slot_load/o_slot_x/o_slot_pattern slot interface;
//        o_done end-of-scan pulse; o_overflow more hits than slots.
// Build option: SPRITE_OVERFLOW_EN keeps scanning after the slots fill and
// reports extra hits on o_overflow; otherwise the scan ends once full.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned       NUM_SPRITES = 16,
  parameter int unsigned       SLOTS       = 6,
  parameter int unsigned       SPR_H       = 16,
  parameter logic [ADDR_W-1:0] ATTR_BASE   = ATTR_BASE_DEF,
  parameter logic [ADDR_W-1:0] PAT_BASE    = PAT_BASE_DEF
) (
  input  logic               px_clk,
  input  logic               rst,
  input  logic               i_line_start,
  input  logic [COORD_W-1:0] i_next_line,
  output logic [ADDR_W-1:0]  o_ram_addr,
  input  logic [DATA_W-1:0]  i_ram_rdata,
  output logic               o_busy,
  output logic               o_slot_clr,
  output logic [SLOTS-1:0]   o_slot_load,
  output logic [COORD_W-1:0] o_slot_x,
  output logic [DATA_W-1:0]  o_slot_pattern,
  output logic               o_done,
  output logic               o_overflow
);

  localparam int unsigned IDX_W = $clog2(NUM_SPRITES);
  localparam int unsigned ROW_W = $clog2(SPR_H);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] SLOTS_C  = CNT_W'(SLOTS);

  state_t r_state, w_next_state;

  logic [COORD_W-1:0] r_line_q, w_line_q_d;
  logic [COORD_W-1:0] r_x, w_x_d;
  logic [IDX_W-1:0]   r_idx, w_idx_d, w_idx_inc;
  logic [ROW_W-1:0]   r_row, w_row_d;
  logic [CNT_W-1:0]   r_slot_cnt, w_slot_cnt_d;

  logic [ADDR_W-1:0]  r_ram_addr, w_ram_addr_d;
  logic               r_busy, w_busy_d;
  logic               r_slot_clr, w_slot_clr_d;
  logic [SLOTS-1:0]   r_slot_load, w_slot_load_d;
  logic [COORD_W-1:0] r_slot_x, w_slot_x_d;
  logic [DATA_W-1:0]  r_slot_pattern, w_slot_pattern_d;
  logic               r_done, w_done_d;

  logic               w_hit, w_full, w_take;
  logic [ROW_W-1:0]   w_row;
  logic [ADDR_W-1:0]  w_attr_next_addr, w_attr_x_addr, w_pat_addr;

  // Attribute word0 is on the read data during CHK
  sprite_y_match #(
    .SPR_H (SPR_H),
    .ROW_W (ROW_W)
  ) u_y_match (
    .i_en    (i_ram_rdata[EN_BIT]),
    .i_y     (i_ram_rdata[Y_MSB:0]),
    .i_line  (r_line_q),
    .o_hit_c (w_hit),
    .o_row_c (w_row)
  );

  assign w_full           = (r_slot_cnt == SLOTS_C);
  assign w_take           = w_hit && !w_full;
  assign w_idx_inc        = IDX_W'(r_idx + 1'b1);
  assign w_attr_next_addr = ATTR_BASE + ADDR_W'({w_idx_inc, 1'b0});
  assign w_attr_x_addr    = ATTR_BASE + ADDR_W'({r_idx, 1'b1});
  assign w_pat_addr       = PAT_BASE + (ADDR_W'(r_idx) << ROW_W) + ADDR_W'(r_row);

  // State register
  always_ff @(posedge px_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a line start restarts the scan from any state
  always_comb begin
    w_next_state = r_state;
    if (i_line_start) begin
      w_next_state = S_RD_Y;
    end else begin
      case (r_state)
        S_IDLE:   w_next_state = S_IDLE;
        S_RD_Y:   w_next_state = S_CHK;
        S_CHK:    w_next_state = w_take ? S_RD_X : S_NEXT;
        S_RD_X:   w_next_state = S_RD_PAT;
        S_RD_PAT: w_next_state = S_LOAD;
        S_LOAD:   w_next_state = S_NEXT;
`ifdef SPRITE_OVERFLOW_EN
        S_NEXT:   w_next_state = (r_idx == LAST_IDX) ? S_DONE : S_RD_Y;
`else
        S_NEXT:   w_next_state = (r_idx == LAST_IDX || w_full) ? S_DONE : S_RD_Y;
`endif
        S_DONE:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef SPRITE_OVERFLOW_EN
  logic r_overflow, w_overflow_d;
`endif

  // Output / datapath next values; RAM address is issued one state ahead of its data
  always_comb begin
    w_line_q_d       = r_line_q;
    w_x_d            = r_x;
    w_idx_d          = r_idx;
    w_row_d          = r_row;
    w_slot_cnt_d     = r_slot_cnt;
    w_ram_addr_d     = r_ram_addr;
    w_slot_x_d       = r_slot_x;
    w_slot_pattern_d = r_slot_pattern;
    w_slot_clr_d     = 1'b0;
    w_slot_load_d    = '0;
    w_done_d         = 1'b0;
    w_busy_d         = (w_next_state != S_IDLE) && (w_next_state != S_DONE);
`ifdef SPRITE_OVERFLOW_EN
    w_overflow_d     = r_overflow;
`endif
    if (i_line_start) begin
      w_line_q_d   = i_next_line;
      w_idx_d      = '0;
      w_slot_cnt_d = '0;
      w_slot_clr_d = 1'b1;
      w_ram_addr_d = ATTR_BASE;
`ifdef SPRITE_OVERFLOW_EN
      w_overflow_d = 1'b0;
`endif
    end else begin
      case (r_state)
        S_CHK: begin
          w_row_d = w_row;
          if (w_take) w_ram_addr_d = w_attr_x_addr;
`ifdef SPRITE_OVERFLOW_EN
          if (w_hit && w_full) w_overflow_d = 1'b1;
`endif
        end
        S_RD_X:   w_ram_addr_d = w_pat_addr;
        S_RD_PAT: w_x_d = i_ram_rdata[X_MSB:0];
        S_LOAD: begin
          w_slot_pattern_d = i_ram_rdata;
          w_slot_x_d       = r_x;
          w_slot_load_d    = SLOTS'(1) << r_slot_cnt;
          w_slot_cnt_d     = CNT_W'(r_slot_cnt + 1'b1);
        end
        S_NEXT: begin
          if (w_next_state == S_RD_Y) begin
            w_idx_d      = w_idx_inc;
            w_ram_addr_d = w_attr_next_addr;
          end else begin
            w_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_line_q       <= '0;
      r_x            <= '0;
      r_idx          <= '0;
      r_row          <= '0;
      r_slot_cnt     <= '0;
      r_ram_addr     <= '0;
      r_busy         <= 1'b0;
      r_slot_clr     <= 1'b0;
      r_slot_load    <= '0;
      r_slot_x       <= '0;
      r_slot_pattern <= '0;
      r_done         <= 1'b0;
    end else begin
      r_line_q       <= w_line_q_d;
      r_x            <= w_x_d;
      r_idx          <= w_idx_d;
      r_row          <= w_row_d;
      r_slot_cnt     <= w_slot_cnt_d;
      r_ram_addr     <= w_ram_addr_d;
      r_busy         <= w_busy_d;
      r_slot_clr     <= w_slot_clr_d;
      r_slot_load    <= w_slot_load_d;
      r_slot_x       <= w_slot_x_d;
      r_slot_pattern <= w_slot_pattern_d;
      r_done         <= w_done_d;
    end
  end

`ifdef SPRITE_OVERFLOW_EN
  always_ff @(posedge px_clk) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= w_overflow_d;
  end
  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_ram_addr     = r_ram_addr;
  assign o_busy         = r_busy;
  assign o_slot_clr     = r_slot_clr;
  assign o_slot_load    = r_slot_load;
  assign o_slot_x       = r_slot_x;
  assign o_slot_pattern = r_slot_pattern;
  assign o_done         = r_done;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a synchronous 512x16 RAM model.
// Scan timing is measured in cycles from the slot_clr cycle (cycle 0).
module tb_sprite_line_scheduler;

  logic        px_clk;
  logic        rst;
  logic        i_line_start;
  logic [9:0]  i_next_line;
  logic [8:0]  o_ram_addr;
  logic [15:0] i_ram_rdata;
  logic        o_busy;
  logic        o_slot_clr;
  logic [5:0]  o_slot_load;
  logic [9:0]  o_slot_x;
  logic [15:0] o_slot_pattern;
  logic        o_done;
  logic        o_overflow;

  logic [15:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state
  int cyc = 0;
  int n_loads = 0;
  int busy_cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int clr_cnt = 0;
  int clr_load_bad = 0;
  int last_pat = 511;
  int ld_mask [8];
  int ld_x [8];
  int ld_pat [8];

  sprite_line_scheduler dut (
    .px_clk         (px_clk),
    .rst            (rst),
    .i_line_start   (i_line_start),
    .i_next_line    (i_next_line),
    .o_ram_addr     (o_ram_addr),
    .i_ram_rdata    (i_ram_rdata),
    .o_busy         (o_busy),
    .o_slot_clr     (o_slot_clr),
    .o_slot_load    (o_slot_load),
    .o_slot_x       (o_slot_x),
    .o_slot_pattern (o_slot_pattern),
    .o_done         (o_done),
    .o_overflow     (o_overflow)
  );

  initial begin
    px_clk = 1'b0;
    forever #5 px_clk = ~px_clk;
  end

  always @(posedge px_clk) i_ram_rdata <= mem[o_ram_addr];

  always @(negedge px_clk) begin
    if (o_slot_clr) begin
      cyc = 0; n_loads = 0; busy_cyc = 0; done_cyc = -1; last_pat = 511;
      clr_cnt++;
      if (|o_slot_load) clr_load_bad++;
    end else begin
      cyc++;
    end
    if (o_busy) busy_cyc++;
    if (o_busy && o_ram_addr < 9'h100) last_pat = int'(o_ram_addr);
    if (|o_slot_load) begin
      if (n_loads < 8) begin
        ld_mask[n_loads] = int'(o_slot_load);
        ld_x[n_loads]    = int'(o_slot_x);
        ld_pat[n_loads]  = int'(o_slot_pattern);
      end
      n_loads++;
    end
    if (o_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge px_clk);
      #1;
    end
  endtask

  task automatic clear_attrs();
    for (int i = 0; i < 16; i++) begin
      mem[256 + 2*i]     = 16'h0000;
      mem[256 + 2*i + 1] = 16'h0000;
    end
  endtask

  task automatic set_spr(input int i, input int y, input int x);
    mem[256 + 2*i]     = 16'h8000 | 16'(y);
    mem[256 + 2*i + 1] = 16'(x);
  endtask

  task automatic pulse_start(input int line);
    i_next_line  = 10'(line);
    i_line_start = 1'b1;
    step(1);
    i_line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != base) break;
      step(1);
    end
    chk(tag, done_cnt - base, 1);
  endtask

  int base_done;
  int base_clr;

  initial begin
    rst = 1'b1;
    i_line_start = 1'b0;
    i_next_line = '0;
    for (int a = 0; a < 512; a++) mem[a] = 16'h1000 + 16'(a);
    clear_attrs();
    step(3);

    // Reset state
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_clr", int'(o_slot_clr), 0);
    chk("rst_load", int'(o_slot_load), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    chk("rst_x", int'(o_slot_x), 0);
    chk("rst_pat", int'(o_slot_pattern), 0);
    chk("rst_addr", int'(o_ram_addr), 0);
    rst = 1'b0;
    step(2);

    // 1: single hit, sprite 0 row 5
    set_spr(0, 100, 40);
    mem[5] = 16'hA5A5;
    base_done = done_cnt;
    pulse_start(105);
    wait_done("t1_done_seen", base_done);
    chk("t1_loads", n_loads, 1);
    chk("t1_mask", ld_mask[0], 1);
    chk("t1_x", ld_x[0], 40);
    chk("t1_pat", ld_pat[0], 16'hA5A5);
    chk("t1_done_cyc", done_cyc, 51);
    chk("t1_busy_cyc", busy_cyc, 51);
    step(2);
    chk("t1_idle_busy", int'(o_busy), 0);

    // 2: no enabled sprites
    clear_attrs();
    base_done = done_cnt;
    base_clr = clr_cnt;
    pulse_start(50);
    wait_done("t2_done_seen", base_done);
    chk("t2_clr_cycles", clr_cnt - base_clr, 1);
    chk("t2_loads", n_loads, 0);
    chk("t2_done_cyc", done_cyc, 48);
    chk("t2_busy_cyc", busy_cyc, 48);
    step(2);

    // 3: y wrap, sprite 3 at y=1020
    set_spr(3, 1020, 7);
    base_done = done_cnt;
    pulse_start(4);
    wait_done("t3a_done_seen", base_done);
    chk("t3a_loads", n_loads, 1);
    chk("t3a_mask", ld_mask[0], 1);
    chk("t3a_x", ld_x[0], 7);
    chk("t3a_pat_addr", last_pat, 56);
    chk("t3a_pat", ld_pat[0], 16'h1038);
    step(2);
    base_done = done_cnt;
    pulse_start(12);
    wait_done("t3b_done_seen", base_done);
    chk("t3b_loads", n_loads, 0);
    chk("t3b_no_pat_addr", last_pat, 511);
    step(2);

    // 4: eight sprites on line 0, six slots
    clear_attrs();
    for (int i = 0; i < 8; i++) set_spr(i, 0, 10*i + 1);
    base_done = done_cnt;
    pulse_start(0);
    wait_done("t4_done_seen", base_done);
    chk("t4_loads", n_loads, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_mask%0d", k), ld_mask[k], 1 << k);
      chk($sformatf("t4_x%0d", k), ld_x[k], 10*k + 1);
      chk($sformatf("t4_pat%0d", k), ld_pat[k], 16'h1000 + 16*k);
    end
`ifdef SPRITE_OVERFLOW_EN
    chk("t4_ovf", int'(o_overflow), 1);
    chk("t4_done_cyc", done_cyc, 66);
`else
    chk("t4_ovf", int'(o_overflow), 0);
    chk("t4_done_cyc", done_cyc, 36);
`endif
    step(2);

    // 5: restart 10 cycles into a scan (during a LOAD), new line 200
    clear_attrs();
    set_spr(2, 100, 99);
    set_spr(5, 195, 55);
    base_clr = clr_cnt;
    pulse_start(100);
    step(10);
    base_done = done_cnt;
    pulse_start(200);
    chk("t5_ovf_cleared", int'(o_overflow), 0);
    wait_done("t5_done_seen", base_done);
    chk("t5_clr_count", clr_cnt - base_clr, 2);
    chk("t5_clr_load", clr_load_bad, 0);
    chk("t5_loads", n_loads, 1);
    chk("t5_mask", ld_mask[0], 1);
    chk("t5_x", ld_x[0], 55);
    chk("t5_pat", ld_pat[0], 16'h1055);
    chk("t5_done_cyc", done_cyc, 51);
    step(2);

    // 6: reset during LOAD of sprite 0
    clear_attrs();
    set_spr(0, 0, 3);
    base_done = done_cnt;
    pulse_start(0);
    step(4);
    rst = 1'b1;
    step(1);
    chk("t6_busy", int'(o_busy), 0);
    chk("t6_load", int'(o_slot_load), 0);
    chk("t6_done", int'(o_done), 0);
    chk("t6_clr", int'(o_slot_clr), 0);
    rst = 1'b0;
    step(5);
    chk("t6_no_loads", n_loads, 0);
    chk("t6_no_done", done_cnt - base_done, 0);
    pulse_start(0);
    wait_done("t6_done_seen", base_done);
    chk("t6_loads", n_loads, 1);
    chk("t6_x", ld_x[0], 3);
    chk("t6_pat", ld_pat[0], 16'h1000);
    chk("t6_done_cyc", done_cyc, 51);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
